// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: state encoding and SRAM geometry.
// No logic; imported by the controller and its phase timer.
package sram_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;
   localparam int          SRAM_AW       = 18;
   localparam int          SRAM_DW       = 16;
   localparam int          WIDX_W        = SRAM_AW - 1;
   localparam int          CNT_W         = 4;

endpackage

// File: rtl/sram_phase_timer.sv
// Counts one halfword phase (0..ACCESS_CYC-1), wrapping so back-to-back phases need no restart.
// last flags the final count; done is last qualified by enable (phase ends at this edge).
module sram_phase_timer
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned ACCESS_CYC = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic en,
   output logic last,
   output logic done
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYC - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || start) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= last ? '0 : cnt + 1'b1;
      end
   end

   assign last = (cnt == LAST_CNT);
   assign done = en & last;

endmodule

// File: rtl/sram_mem_ctrl.sv
// Splits 32-bit MEM-stage accesses into two ACCESS_CYC-cycle halfword SRAM phases (low, then high).
// ready pulses 2*ACCESS_CYC+1 cycles after the request; stall holds the pipeline until then.
module sram_mem_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned ACCESS_CYC = 2,
   parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mem_rd_en,
   input  logic               mem_wr_en,
   input  logic [31:0]        mem_addr,
   input  logic [31:0]        mem_wr_data,
   output logic [31:0]        mem_rd_data,
   output logic               ready,
   output logic               stall,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [SRAM_DW-1:0] sram_dq_out,
   output logic               sram_dq_oe,
   input  logic [SRAM_DW-1:0] sram_dq_in,
   output logic               sram_we_n
);

   state_t              state, state_nxt;
   logic                op_wr;
   logic [WIDX_W-1:0]   widx;
   logic [31:0]         wdat;
   logic                req;
   logic                in_phase;
   logic                ph_last;
   logic                ph_done;

   assign req      = mem_rd_en | mem_wr_en;
   assign in_phase = (state == ST_LO) || (state == ST_HI);

   sram_phase_timer #(
      .ACCESS_CYC (ACCESS_CYC)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .start (~in_phase),
      .en    (in_phase),
      .last  (ph_last),
      .done  (ph_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (req)     state_nxt = ST_LO;
         ST_LO:   if (ph_done) state_nxt = ST_HI;
         ST_HI:   if (ph_done) state_nxt = ST_DONE;
         ST_DONE:              state_nxt = ST_IDLE;
         default:              state_nxt = ST_IDLE;
      endcase
   end

   // Write wins when both enables are high; read data is captured on the last count of each phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_wr       <= 1'b0;
         widx        <= '0;
         wdat        <= '0;
         mem_rd_data <= '0;
      end else begin
         if (state == ST_IDLE && req) begin
            op_wr <= mem_wr_en;
            widx  <= WIDX_W'((mem_addr - BASE_ADDR) >> 2);
            wdat  <= mem_wr_data;
         end
         if (ph_done && !op_wr) begin
            if (state == ST_LO) begin
               mem_rd_data[15:0] <= sram_dq_in;
            end else begin
               mem_rd_data[31:16] <= sram_dq_in;
            end
         end
      end
   end

   // WE rises one count before the phase ends so address and data are held past the edge.
   assign sram_addr   = {widx, (state == ST_HI)};
   assign sram_dq_out = (state == ST_HI) ? wdat[31:16] : wdat[15:0];
   assign sram_dq_oe  = op_wr & in_phase;
   assign sram_we_n   = ~(sram_dq_oe & ~ph_last);
   assign ready       = (state == ST_DONE);
   assign stall       = req & ~ready;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Bench for sram_mem_ctrl: directed pin-level traces plus randomized word traffic against a word-level memory model.
// A second instance with ACCESS_CYC=4 checks the longer latency.
module tb_sram_mem_ctrl;

   localparam int          A    = 2;
   localparam int          A4   = 4;
   localparam logic [31:0] BASE = 32'd1024;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        rd_en, wr_en;
   logic [31:0] addr, wdata, rd_data;
   logic        ready, stall;
   logic [17:0] s_addr;
   logic [15:0] s_dout, s_din;
   logic        s_oe, s_we_n;

   logic        rd_en4, wr_en4;
   logic [31:0] addr4, wdata4, rd_data4;
   logic        ready4, stall4;
   logic [17:0] s_addr4;
   logic [15:0] s_dout4;
   logic [15:0] s_din4;
   logic        s_oe4, s_we_n4;

   int total = 0;
   int bad   = 0;

   logic [15:0] sram [0:262143];
   logic [31:0] ref_mem [logic [16:0]];
   logic [31:0] last_rd;

   sram_mem_ctrl #(.ACCESS_CYC(A), .BASE_ADDR(BASE)) u_dut (
      .clk(clk), .rst(rst), .mem_rd_en(rd_en), .mem_wr_en(wr_en), .mem_addr(addr),
      .mem_wr_data(wdata), .mem_rd_data(rd_data), .ready(ready), .stall(stall),
      .sram_addr(s_addr), .sram_dq_out(s_dout), .sram_dq_oe(s_oe), .sram_dq_in(s_din),
      .sram_we_n(s_we_n)
   );

   sram_mem_ctrl #(.ACCESS_CYC(A4), .BASE_ADDR(BASE)) u_dut4 (
      .clk(clk), .rst(rst), .mem_rd_en(rd_en4), .mem_wr_en(wr_en4), .mem_addr(addr4),
      .mem_wr_data(wdata4), .mem_rd_data(rd_data4), .ready(ready4), .stall(stall4),
      .sram_addr(s_addr4), .sram_dq_out(s_dout4), .sram_dq_oe(s_oe4), .sram_dq_in(s_din4),
      .sram_we_n(s_we_n4)
   );

   // Board SRAM: latches data while WE is low, presents read data before the next capture edge.
   always @(posedge clk) if (s_oe && !s_we_n) sram[s_addr] <= s_dout;
   always @(negedge clk) s_din = sram[s_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [16:0] widx_of(input logic [31:0] a);
      logic [31:0] d;
      d = (a - BASE) / 4;
      return d[16:0];
   endfunction

   task automatic idle(input int n);
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("idle_stall", stall, 0);
         check("idle_ready", ready, 0);
         if (i < n - 1) @(posedge clk);
      end
   endtask

   // One word op; expected pin trace derived from phase/count arithmetic of the access.
   task automatic do_op(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                        input bit drop);
      int          cyc;
      bit          seen;
      int          ph, k;
      logic [16:0] w;
      logic [31:0] exp;
      w = widx_of(a);
      @(posedge clk); #1;
      wr_en = wr; rd_en = rd; addr = a; wdata = d;
      cyc = 0; seen = 0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         if (cyc == 0) begin
            check("idle_oe", s_oe, 0);
            check("idle_we_n", s_we_n, 1);
         end else if (cyc <= 2 * A) begin
            ph = (cyc - 1) / A;
            k  = (cyc - 1) % A;
            check("sram_addr", 32'(s_addr), 32'({w, ph == 1}));
            check("dq_oe", 32'(s_oe), 32'(wr));
            check("we_n", 32'(s_we_n), wr ? 32'(k == A - 1) : 32'd1);
            if (wr) check("dq_out", 32'(s_dout), (ph == 1) ? 32'(d[31:16]) : 32'(d[15:0]));
         end
         if (ready) begin
            seen = 1;
            check("ready_cyc", cyc, 2 * A + 1);
            check("stall_at_ready", stall, 0);
         end else begin
            check("stall", stall, (drop && cyc > 0) ? 0 : 1);
            @(posedge clk); #1;
            if (drop) begin wr_en = 1'b0; rd_en = 1'b0; end
            cyc++;
         end
      end
      if (!seen) check("ready_timeout", 0, 1);
      if (wr) begin
         ref_mem[w] = d;
         check("rd_hold", rd_data, last_rd);
      end else begin
         exp = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
         check("rd_data", rd_data, exp);
         last_rd = exp;
      end
   endtask

   task automatic op4(input bit wr, input logic [31:0] a, input logic [31:0] d);
      int cyc;
      @(posedge clk); #1;
      wr_en4 = wr; rd_en4 = ~wr; addr4 = a; wdata4 = d;
      cyc = 0;
      @(negedge clk);
      while (!ready4 && cyc < 60) begin
         @(posedge clk); #1;
         @(negedge clk);
         cyc++;
      end
      check("a4_ready_cyc", cyc, 2 * A4 + 1);
      if (!wr) check("a4_rd_data", rd_data4, 32'h5A5A5A5A);
   endtask

   initial begin
      logic [31:0] a, d;
      int          r;
      for (int i = 0; i < 262144; i++) sram[i] = 16'h0;
      s_din4 = 16'h5A5A;
      last_rd = 32'h0;
      rst = 1'b1; rd_en = 0; wr_en = 0; addr = 0; wdata = 0;
      rd_en4 = 0; wr_en4 = 0; addr4 = 0; wdata4 = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", ready, 0);
      check("rst_stall", stall, 0);
      check("rst_we_n", s_we_n, 1);
      check("rst_oe", s_oe, 0);
      check("rst_addr", 32'(s_addr), 0);
      check("rst_dq_out", 32'(s_dout), 0);
      check("rst_rd_data", rd_data, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      do_op(1, 0, BASE, 32'h1234ABCD, 0);
      idle(2);
      do_op(0, 1, BASE, 32'h0, 0);
      check("rd_first", rd_data, 32'h1234ABCD);
      idle(1);
      do_op(1, 0, BASE + 4, 32'h0BADF00D, 0);
      do_op(0, 1, BASE + 4, 32'h0, 0);
      do_op(1, 0, BASE - 4, 32'h55AA33CC, 0);
      do_op(0, 1, BASE - 4, 32'h0, 0);
      check("wrap_rd", rd_data, 32'h55AA33CC);
      check("wrap_hw", 32'(sram[18'h3FFFE]), 32'h33CC);
      do_op(1, 1, BASE + 12, 32'hDEADBEEF, 0);
      do_op(0, 1, BASE + 12, 32'h0, 0);
      check("both_rd", rd_data, 32'hDEADBEEF);
      idle(1);

      // Reset lands in cycle 3 of a write: no ready, clean pins, controller usable afterwards.
      @(posedge clk); #1;
      wr_en = 1'b1; addr = BASE + 8; wdata = 32'hCAFEF00D;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; wr_en = 1'b0;
      @(negedge clk);
      check("abort_we_n", s_we_n, 1);
      check("abort_oe", s_oe, 0);
      check("abort_addr", 32'(s_addr), 0);
      check("abort_rd_data", rd_data, 0);
      last_rd = 32'h0;
      for (int i = 0; i < 6; i++) begin
         check("abort_no_ready", ready, 0);
         @(negedge clk);
      end
      do_op(1, 0, BASE + 8, 32'hFEEDC0DE, 0);
      do_op(0, 1, BASE + 8, 32'h0, 0);
      idle(1);

      for (int n = 0; n < 40; n++) begin
         a = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFC)
                                         : BASE + 32'($urandom_range(0, 7)) * 4;
         d = $urandom;
         r = $urandom_range(0, 3);
         do_op(r < 2 || r == 3, r >= 2, a, d, $urandom_range(0, 3) == 0);
         r = $urandom_range(0, 2);
         if (r != 0) idle(r);
      end
      idle(1);

      op4(1, BASE, 32'h11112222);
      op4(0, BASE, 32'h0);
      @(posedge clk); #1;
      wr_en4 = 1'b0; rd_en4 = 1'b0;
      repeat (2) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram_mem_ctrl.md
Name: sram_mem_ctrl

Overview:
Sequences the board's 16-bit SRAM for the pipeline's MEM stage, which makes 32-bit word accesses. Each read or write is split into two halfword phases (low, then high), each phase lasting ACCESS_CYC cycles. While the access is in progress the controller holds the pipeline through a ready/stall handshake. It sits between the MEM stage of the ARMSIM core and the top-level SRAM pins; the top level owns the tristate (SRAM_DQ = sram_dq_oe ? sram_dq_out : 'z) and ties CE_N/OE_N/UB_N/LB_N low.

Parameters:
ACCESS_CYC, 2, cycles per halfword phase; legal range 2..15.
BASE_ADDR, 1024, byte address of the first data word; subtracted before mapping to SRAM.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
mem_rd_en  in  1  word read request from MEM stage
mem_wr_en  in  1  word write request from MEM stage
mem_addr  in  32  byte address, word aligned (bits [1:0] ignored)
mem_wr_data  in  32  write data
mem_rd_data  out  32  read data, valid when ready=1 for a read
ready  out  1  one-cycle pulse: transaction complete
stall  out  1  mem_rd_en|mem_wr_en and not ready; freezes the pipeline
sram_addr  out  18  halfword address
sram_dq_out  out  16  write data to the pad
sram_dq_oe  out  1  pad output enable
sram_dq_in  in  16  read data from the pad
sram_we_n  out  1  write enable, active low

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - state=IDLE.
  - sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0, ready=0, mem_rd_data=0, phase counter=0.
  - rst asserted mid-transaction aborts it: no ready pulse, and any write may be left partial.
- Address mapping: widx = (mem_addr - BASE_ADDR) >> 2, truncated to 17 bits. Low phase addr = {widx,1'b0}; high phase addr = {widx,1'b1}. Out-of-range addresses wrap silently; no error is flagged.
- States: IDLE -> LO -> HI -> DONE -> IDLE.
- IDLE:
  - If mem_wr_en or mem_rd_en is high, latch op, address and wr_data, then go to LO.
  - If both are high, the write wins and the read is ignored.
- LO / HI phases:
  - Each lasts exactly ACCESS_CYC cycles, counted by the phase counter (0..ACCESS_CYC-1).
  - Write phase:
    - sram_addr and sram_dq_out are held for the whole phase: LO drives wr_data[15:0], HI drives wr_data[31:16].
    - sram_dq_oe=1 for the whole phase.
    - sram_we_n=0 for counts 0..ACCESS_CYC-2 and 1 in the last count, giving address/data hold at the WE rising edge.
  - Read phase:
    - sram_dq_oe=0 and sram_we_n=1.
    - sram_dq_in is captured at the edge ending the last count: into rd_data[15:0] in LO, rd_data[31:16] in HI.
- DONE:
  - ready=1 for exactly one cycle, sram_dq_oe=0, sram_we_n=1; next state is IDLE.
  - mem_rd_data is updated only by reads and holds its value otherwise.
- Latency: with the request first seen in IDLE at cycle 0, LO covers cycles 1..A and HI covers A+1..2A. ready is high in cycle 2A+1 (cycle 5 for A=2). The next request is accepted in IDLE at cycle 2A+2 at the earliest.
- Request handling while busy:
  - Dropping the request mid-transaction does not abort it; the transaction completes.
  - A request still high in DONE is not re-issued; the pipeline advances on ready, so back-to-back ops reuse IDLE.
- stall is combinational: (mem_rd_en|mem_wr_en) & ~ready. It is 0 when there is no request.

Decomposition:
- Shared package sram_ctrl_pkg holds:
  - the state encoding (IDLE/LO/HI/DONE, 2 bits);
  - the BASE_ADDR default;
  - SRAM_AW=18 and SRAM_DW=16.
- One sub-module, sram_phase_timer: counter 0..ACCESS_CYC-1 with a start input and last/done outputs, reset synchronously.
- The FSM, address mapping and data capture stay in sram_mem_ctrl.

Test Plan:
- Write 0x1234ABCD to address 1024 (A=2) -> cycles 1-2: addr=0, dq_out=0xABCD, we_n=0,1. Cycles 3-4: addr=1, dq_out=0x1234, we_n=0,1. dq_oe=1 in cycles 1-4. ready=1 in cycle 5 only; stall=1 in cycles 0-4.
- Read address 1024 with the behavioural SRAM model holding the above -> mem_rd_data=0x1234ABCD when ready=1; we_n stays 1 and dq_oe stays 0 throughout.
- Address 1028 and address 1020 -> halfwords 2/3 and 0x3FFFE/0x3FFFF (wrap, 17-bit truncation).
- mem_rd_en=mem_wr_en=1 with data 0xDEADBEEF -> write performed, mem_rd_data unchanged; a following read returns 0xDEADBEEF.
- rst=1 in cycle 3 of a write -> next cycle state IDLE, we_n=1, dq_oe=0, no ready pulse; a following write completes normally.
- Back-to-back write then read, with ready driving the request change -> second op starts in IDLE the cycle after ready; ACCESS_CYC=4 run gives ready at cycle 9.
